// File: rtl/token_pkg.sv
// Constants and helpers shared by the token-stream modules.
package token_pkg;

    // Default output tokens emitted per input token.
    localparam int unsigned TokenFactorDef = 2;
    // Default backlog counter width.
    localparam int unsigned TokenCntWDef   = 4;

    // Largest backlog a counter of width cnt_w can hold.
    function automatic int unsigned token_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/multiply_tokens.sv
// Token multiplier: every '1' on a is turned into FACTOR '1's on b, emitted one per cycle.
// The first output token leaves in the same cycle as the input token. The remainder
// wait in a saturating backlog counter. Tokens lost to saturation raise a sticky ovf flag.
module multiply_tokens
    import token_pkg::*;
#(
    parameter int unsigned FACTOR = TokenFactorDef,
    parameter int unsigned CNT_W  = TokenCntWDef
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             clr_ovf,
    output logic             b,
    output logic [CNT_W-1:0] backlog,
    output logic             ovf
);

    // A factor of zero or one the counter cannot hold is a configuration error.
    if (FACTOR < 1 || FACTOR > token_max(CNT_W)) begin : g_bad_factor
        $error("multiply_tokens: FACTOR must be in 1..2^CNT_W-1");
    end

    // The per-token increment is FACTOR-1 because one token leaves in the same cycle.
    localparam logic [CNT_W:0]   Inc  = (CNT_W + 1)'(FACTOR - 1);
    localparam logic [CNT_W:0]   MaxW = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] One  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W:0]   sum;
    logic             sat;

    // Next-state logic: grow on input tokens (saturating), drain one per idle cycle.
    always_comb begin
        sum   = {1'b0, cnt_q} + Inc;
        sat   = a && (sum > MaxW);
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (a) begin
            cnt_d = sat ? MaxW[CNT_W-1:0] : sum[CNT_W-1:0];
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - One;
        end
        // A saturation in the same cycle as a clear keeps the flag set.
        if (sat) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset; input tokens are dropped in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Outputs: b is combinational so the first token of a burst has no latency.
    always_comb begin
        b       = !rst && (a || (cnt_q != '0));
        backlog = rst ? '0 : cnt_q;
        ovf     = ovf_q;
    end

endmodule

// File: tb/tb_multiply_tokens.sv
// Scoreboard bench for multiply_tokens: three instances (FACTOR 1, 2, 3) share one input
// stream; a token-owed reference model predicts each cycle's outputs into a queue that a
// separate monitor drains.
module tb_multiply_tokens;

    localparam int unsigned CntW = 4;
    localparam int unsigned Max  = 15;

    typedef struct packed {
        logic            b;
        logic [CntW-1:0] bl;
        logic            ovf;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0;
    logic clr_ovf = 1'b0;

    logic            b1, b2, b3;
    logic [CntW-1:0] bl1, bl2, bl3;
    logic            ovf1, ovf2, ovf3;

    logic            act_b   [3];
    logic [CntW-1:0] act_bl  [3];
    logic            act_ovf [3];

    assign act_b[0] = b1;   assign act_bl[0] = bl1;   assign act_ovf[0] = ovf1;
    assign act_b[1] = b2;   assign act_bl[1] = bl2;   assign act_ovf[1] = ovf2;
    assign act_b[2] = b3;   assign act_bl[2] = bl3;   assign act_ovf[2] = ovf3;

    multiply_tokens #(.FACTOR(1), .CNT_W(CntW)) u_f1 (
        .clk(clk), .rst(rst), .a(a), .clr_ovf(clr_ovf), .b(b1), .backlog(bl1), .ovf(ovf1)
    );
    multiply_tokens #(.FACTOR(2), .CNT_W(CntW)) u_f2 (
        .clk(clk), .rst(rst), .a(a), .clr_ovf(clr_ovf), .b(b2), .backlog(bl2), .ovf(ovf2)
    );
    multiply_tokens #(.FACTOR(3), .CNT_W(CntW)) u_f3 (
        .clk(clk), .rst(rst), .a(a), .clr_ovf(clr_ovf), .b(b3), .backlog(bl3), .ovf(ovf3)
    );

    always #5 clk = ~clk;

    int unsigned fac [3] = '{1, 2, 3};
    int unsigned pend [3];
    bit          movf [3];
    exp3_t       sb_q [$];
    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;

    task automatic check(input string name, input int unsigned inst, input int unsigned act,
                         input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s F=%0d cycle %0d: got %0d expected %0d", name, fac[inst], cycle,
                     act, exp);
        end
    endtask

    // Reference model: count tokens still owed; one leaves per cycle, overflow beyond Max is lost.
    task automatic drive(input bit a_v, input bit clr_v, input bit rst_v);
        exp3_t e;
        int unsigned owed;
        @(negedge clk);
        a       = a_v;
        clr_ovf = clr_v;
        rst     = rst_v;
        cycle++;
        for (int i = 0; i < 3; i++) begin
            if (rst_v) begin
                e[i].b  = 1'b0;
                pend[i] = 0;
                movf[i] = 1'b0;
            end else begin
                owed   = pend[i] + (a_v ? fac[i] : 0);
                e[i].b = (owed > 0);
                if (owed > 0) owed = owed - 1;
                if (owed > Max) begin
                    owed    = Max;
                    movf[i] = 1'b1;
                end else if (clr_v) begin
                    movf[i] = 1'b0;
                end
                pend[i] = owed;
            end
            e[i].bl  = CntW'(pend[i]);
            e[i].ovf = movf[i];
        end
        sb_q.push_back(e);
    endtask

    // Monitor: b is sampled mid-cycle, registered outputs just after the edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                exp3_t e;
                logic  sb [3];
                e = sb_q.pop_front();
                for (int i = 0; i < 3; i++) sb[i] = act_b[i];
                @(posedge clk);
                #1;
                for (int i = 0; i < 3; i++) begin
                    check("b", i, int'(sb[i]), int'(e[i].b));
                    check("backlog", i, int'(act_bl[i]), int'(e[i].bl));
                    check("ovf", i, int'(act_ovf[i]), int'(e[i].ovf));
                end
            end
        end
    end

    initial begin
        drive(0, 0, 1);
        drive(0, 0, 1);
        // Single token, then a pair of adjacent tokens.
        drive(1, 0, 0); repeat (4) drive(0, 0, 0);
        drive(1, 0, 0); drive(1, 0, 0); repeat (6) drive(0, 0, 0);
        // Sixteen back-to-back tokens saturate the backlog, then drain fully.
        repeat (16) drive(1, 0, 0);
        repeat (20) drive(0, 0, 0);
        // Clear the sticky flag, then refill with a clear during the saturating cycle.
        drive(0, 1, 0); drive(0, 0, 0);
        repeat (15) drive(1, 0, 0);
        drive(1, 1, 0);
        drive(0, 1, 0);
        repeat (20) drive(0, 0, 0);
        // Reset in the middle of a burst discards the backlog.
        drive(1, 0, 0); drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
        // Tokens presented during reset are dropped.
        drive(1, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 49) == 0);
        end
        repeat (20) drive(0, 0, 0);
        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiply_tokens.md
MULTIPLY_TOKENS -- requirements
Module: multiply_tokens

Interface
REQ-001 The block SHALL have parameter FACTOR, default 2: output '1' tokens emitted per input '1' token.
REQ-002 The block SHALL have parameter CNT_W, default 4: backlog counter width, so MAX = 2^CNT_W-1.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port a, input, 1 bit: serial input token stream, '1' = token.
REQ-006 The block SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-007 The block SHALL have port b, output, 1 bit: serial output token stream.
REQ-008 The block SHALL have port backlog, output, CNT_W bits: pending output tokens not yet emitted (registered cnt).
REQ-009 The block SHALL have port ovf, output, 1 bit: sticky flag, tokens lost to saturation.

Function
REQ-010 The block SHALL emit FACTOR output '1's per input '1', one per cycle, with zero latency for the first.
REQ-011 b SHALL be combinational: b = !rst & (a | (cnt != 0)).
REQ-012 Each cycle with b=1 SHALL consume exactly one token.
REQ-013 When a=1 and no saturation occurs, the counter SHALL update cnt_next = cnt + FACTOR - 1.
REQ-014 When a=0 and cnt>0, the counter SHALL update cnt_next = cnt - 1.
REQ-015 When a=0 and cnt=0, cnt SHALL hold at 0 and b SHALL be 0.
REQ-016 The addition SHALL be computed at width CNT_W+1 with no wrap-around; if cnt + FACTOR - 1 > MAX, cnt_next SHALL be MAX and ovf SHALL be set on the next edge.
REQ-017 ovf SHALL remain 1 until rst or clr_ovf=1.
REQ-018 If clr_ovf=1 and a saturation event occur in the same cycle, set SHALL win and ovf SHALL stay 1.
REQ-019 With FACTOR=1, cnt SHALL stay 0 and b SHALL equal a (pass-through).
REQ-020 FACTOR < 1 or FACTOR > MAX SHALL be rejected at elaboration.

Reset
REQ-021 While rst=1, on each clk edge the block SHALL set cnt=0 and ovf=0.
REQ-022 While rst=1, b SHALL be 0 and backlog SHALL be 0.
REQ-023 Tokens presented on a while rst=1 SHALL be discarded.
REQ-024 Reset asserted mid-burst SHALL discard the pending backlog with no further output tokens after release.

Structure
REQ-025 Package token_pkg SHALL hold the default FACTOR and CNT_W constants shared with the token-stream modules.
REQ-026 The block SHALL be a single module, with one counter register, one ovf register, and combinational next-state and output logic; no sub-module.

Verification
REQ-027 FACTOR=2, a=1,0,0,0 -> b=1,1,0,0; backlog after each edge=1,0,0,0.
REQ-028 FACTOR=2, a=1,1,0,0,0 -> b=1,1,1,1,0; backlog=1,2,1,0,0.
REQ-029 FACTOR=2, CNT_W=4, a=1 for 16 cycles then 0 -> backlog reaches 15 after 15 cycles and saturates on the 16th; ovf=1 from cycle 17; b stays 1 for 15 further cycles, then 0.
REQ-030 After REQ-029, clr_ovf=1 for one cycle -> ovf=0 next cycle; clr_ovf=1 during a saturating a=1 cycle -> ovf stays 1.
REQ-031 FACTOR=3, a=1,0,0,0, with rst=1 in cycle 2 -> b=1,0,0,0; backlog=0 after the reset edge; ovf=0.
REQ-032 FACTOR=1, random a for 100 cycles -> b==a every cycle; backlog=0 throughout.
